wiener_stats_sequencer: RTL and testbench

- Frame-level controller that feeds the Wiener block-statistics datapath from a valid/ready pixel stream.
- Gates each block in as a gap-free burst of TOTAL_SAMPLES samples and generates start_data, start_of_frame and end_of_frame.
- Caps the number of blocks in flight using the datapath's variance_ready pulses, and reports frame completion and errors.
- Sits between the frame buffer reader and the block-stats datapath.

---
 rtl/wiener_pkg.sv | 29 ++
 rtl/wiener_stats_sequencer_if.sv | 27 ++
 rtl/wiener_seq_credit_cnt.sv | 39 +++
 rtl/wiener_stats_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_wiener_stats_sequencer.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/wiener_pkg.sv
// Shared types and constants for the Wiener block-statistics sequencer:
// FSM state encoding, error codes and the in-flight counter width helper.
package wiener_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SOF,
        ST_WAIT_CREDIT,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE,
        ST_ERROR
    } seq_state_t;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_CFG      = 2'd1;
    localparam logic [1:0] ERR_UNDERRUN = 2'd2;
    localparam logic [1:0] ERR_SPURIOUS = 2'd3;

    localparam int DEFAULT_MAX_INFLIGHT = 2;

    // Bits needed to hold 0..max_inflight inclusive.
    function automatic int inflight_width(input int max_inflight);
        return $clog2(max_inflight + 1);
    endfunction

    localparam int INFLIGHT_W = inflight_width(DEFAULT_MAX_INFLIGHT);

endpackage

// File: rtl/wiener_stats_sequencer_if.sv
// Stream-side signals of the sequencer: upstream valid/ready pixel input,
// downstream sample/marker outputs and the datapath completion pulse.
// slave = sequencer side, master = frame reader / datapath side.
interface wiener_stats_sequencer_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  s_valid;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] stats_data;
    logic                  stats_start_data;
    logic                  stats_start_of_frame;
    logic                  stats_end_of_frame;
    logic                  variance_ready;

    modport master (
        output s_valid, s_data, variance_ready,
        input  s_ready, stats_data, stats_start_data,
               stats_start_of_frame, stats_end_of_frame
    );

    modport slave (
        input  s_valid, s_data, variance_ready,
        output s_ready, stats_data, stats_start_data,
               stats_start_of_frame, stats_end_of_frame
    );
endinterface

// File: rtl/wiener_seq_credit_cnt.sv
// Saturating up/down counter of blocks started but not yet reported done.
// Simultaneous inc and dec leave the count unchanged; a dec with nothing
// outstanding raises underflow and the count stays at zero.
module wiener_seq_credit_cnt
    import wiener_pkg::*;
#(
    parameter int MAX = DEFAULT_MAX_INFLIGHT,
    parameter int W   = INFLIGHT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    input  logic dec,
    output logic full,
    output logic empty,
    output logic underflow
);
    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] count_q;

    assign full      = (count_q == MAX_V);
    assign empty     = (count_q == '0);
    assign underflow = dec && !inc && empty;

    // Track outstanding blocks, saturating at both ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (inc && !dec && !full) begin
            count_q <= count_q + W'(1);
        end else if (dec && !inc && !empty) begin
            count_q <= count_q - W'(1);
        end
    end
endmodule

// File: rtl/wiener_stats_sequencer.sv
// Frame-level controller feeding the Wiener block-statistics datapath.
// Optional drain/credit watchdog: define WIENER_SEQ_TIMEOUT_EN.
//
// state          | meaning
// ST_IDLE        | waiting for frame_start
// ST_SOF         | start_of_frame pulse on the outputs
// ST_WAIT_CREDIT | waiting for a free credit and s_valid before a block
// ST_STREAM      | accepting a gap-free block of TOTAL_SAMPLES samples
// ST_DRAIN       | all blocks sent, waiting for outstanding variance_ready
// ST_DONE        | frame_done pulse on the outputs
// ST_ERROR       | sticky error, left only via frame_start or reset
module wiener_stats_sequencer
    import wiener_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int TOTAL_SAMPLES  = 8,
    parameter int MAX_INFLIGHT   = DEFAULT_MAX_INFLIGHT
`ifdef WIENER_SEQ_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     frame_start,
    input  logic [31:0]              blocks_per_frame,
    wiener_stats_sequencer_if.slave  bus,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     err,
    output logic [1:0]               err_code
);
    localparam int SW = $clog2(TOTAL_SAMPLES);
    localparam int CW = inflight_width(MAX_INFLIGHT);
    localparam logic [SW-1:0] LAST_IDX = SW'(TOTAL_SAMPLES - 1);

    seq_state_t            state_q, state_nxt;
    logic [31:0]           frame_blocks_q;
    logic [31:0]           block_cnt_q;
    logic [SW-1:0]         sample_cnt_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  ready_q, start_q, sof_q, eof_q;
    logic                  accept, first, last, frame_end, credit_ok, fs_take, spurious;
    logic                  full, empty, underflow;
    logic                  err_set;
    logic [1:0]            err_code_nxt;

    assign bus.s_ready              = ready_q;
    assign bus.stats_data           = data_q;
    assign bus.stats_start_data     = start_q;
    assign bus.stats_start_of_frame = sof_q;
    assign bus.stats_end_of_frame   = eof_q;

    assign accept    = (state_q == ST_STREAM) && bus.s_valid;
    assign first     = accept && (sample_cnt_q == '0);
    assign last      = accept && (sample_cnt_q == LAST_IDX);
    assign frame_end = last && ((block_cnt_q + 32'd1) == frame_blocks_q);
    // A credit returned this very cycle may be spent immediately.
    assign credit_ok = !full || bus.variance_ready;
    assign fs_take   = frame_start && ((state_q == ST_IDLE) || (state_q == ST_ERROR));
    assign spurious  = underflow && (state_q != ST_ERROR);

`ifdef WIENER_SEQ_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WDW-1:0] wd_cnt_q;
    logic           wd_run, wd_hit;
    assign wd_run = (state_q == ST_DRAIN) || ((state_q == ST_WAIT_CREDIT) && full);
    assign wd_hit = wd_run && !bus.variance_ready && (wd_cnt_q == WDW'(TIMEOUT_CYCLES - 1));
`else
    logic wd_hit;
    assign wd_hit = 1'b0;
`endif

    wiener_seq_credit_cnt #(
        .MAX (MAX_INFLIGHT),
        .W   (CW)
    ) u_credit (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (fs_take),
        .inc       (first),
        .dec       (bus.variance_ready),
        .full      (full),
        .empty     (empty),
        .underflow (underflow)
    );

    // Next-state and error decode; spurious/timeout errors override everything.
    always_comb begin
        state_nxt    = state_q;
        err_set      = 1'b0;
        err_code_nxt = ERR_NONE;
        case (state_q)
            ST_IDLE, ST_ERROR: begin
                if (fs_take) begin
                    if (blocks_per_frame == 32'd0) begin
                        state_nxt    = ST_ERROR;
                        err_set      = 1'b1;
                        err_code_nxt = ERR_CFG;
                    end else begin
                        state_nxt = ST_SOF;
                    end
                end
            end
            ST_SOF: state_nxt = ST_WAIT_CREDIT;
            ST_WAIT_CREDIT: begin
                if (credit_ok && bus.s_valid) state_nxt = ST_STREAM;
            end
            ST_STREAM: begin
                if (!bus.s_valid) begin
                    state_nxt    = ST_ERROR;
                    err_set      = 1'b1;
                    err_code_nxt = ERR_UNDERRUN;
                end else if (frame_end) begin
                    state_nxt = ST_DRAIN;
                end else if (last && !credit_ok) begin
                    state_nxt = ST_WAIT_CREDIT;
                end
            end
            ST_DRAIN: begin
                if (empty) state_nxt = ST_DONE;
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        if (spurious || wd_hit) begin
            state_nxt    = ST_ERROR;
            err_set      = 1'b1;
            err_code_nxt = ERR_SPURIOUS;
        end
    end

    // State, counters and registered outputs (decoded from the next state).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            frame_blocks_q <= '0;
            block_cnt_q    <= '0;
            sample_cnt_q   <= '0;
            data_q         <= '0;
            ready_q        <= 1'b0;
            start_q        <= 1'b0;
            sof_q          <= 1'b0;
            eof_q          <= 1'b0;
            busy           <= 1'b0;
            frame_done     <= 1'b0;
            err            <= 1'b0;
            err_code       <= ERR_NONE;
`ifdef WIENER_SEQ_TIMEOUT_EN
            wd_cnt_q       <= '0;
`endif
        end else begin
            state_q    <= state_nxt;
            ready_q    <= (state_nxt == ST_STREAM);
            busy       <= (state_nxt != ST_IDLE);
            sof_q      <= (state_nxt == ST_SOF);
            frame_done <= (state_nxt == ST_DONE);
            start_q    <= first;
            eof_q      <= frame_end;
            if (accept) begin
                data_q       <= bus.s_data;
                sample_cnt_q <= sample_cnt_q + SW'(1);
            end
            if (last) block_cnt_q <= block_cnt_q + 32'd1;
            if (fs_take) begin
                frame_blocks_q <= blocks_per_frame;
                block_cnt_q    <= '0;
                sample_cnt_q   <= '0;
                err            <= 1'b0;
                err_code       <= ERR_NONE;
            end
            if (err_set) begin
                err      <= 1'b1;
                err_code <= err_code_nxt;
            end
`ifdef WIENER_SEQ_TIMEOUT_EN
            if (!wd_run || bus.variance_ready) wd_cnt_q <= '0;
            else                               wd_cnt_q <= wd_cnt_q + WDW'(1);
`endif
        end
    end
endmodule

// File: tb/tb_wiener_stats_sequencer.sv
// Directed bench for wiener_stats_sequencer (TOTAL_SAMPLES=8, MAX_INFLIGHT=2).
// Cycle c of a frame run is observed 1 time unit after the c-th rising edge;
// inputs set at cycle c are sampled by the DUT on edge c+1.
module tb_wiener_stats_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_start;
    logic [31:0] blocks_per_frame;
    logic        busy, frame_done, err;
    logic [1:0]  err_code;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    int   sd_cyc[$];
    int   sof_cyc, eof_cyc, done_cyc, acc_cnt, drop_acc;
    logic [7:0] dat_log  [0:127];
    logic       err_log  [0:127];
    logic [1:0] code_log [0:127];
    logic       busy_log [0:127];
    logic       ready_log[0:127];

    wiener_stats_sequencer_if #(.DATA_WIDTH(8)) bus ();

    wiener_stats_sequencer #(
        .DATA_WIDTH    (8),
        .TOTAL_SAMPLES (8),
        .MAX_INFLIGHT  (2)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .frame_start      (frame_start),
        .blocks_per_frame (blocks_per_frame),
        .bus              (bus),
        .busy             (busy),
        .frame_done       (frame_done),
        .err              (err),
        .err_code         (err_code)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int sd_at(input int i);
        if (i < sd_cyc.size()) return sd_cyc[i];
        return -1;
    endfunction

    // Runs ncyc cycles: frame_start at cycle 0, s_valid high until cycle voff
    // (voff<0: always), variance_ready set at cycles vr0/vr1/vr2.
    task automatic run_frame(input logic [31:0] nblk, input int vr0, input int vr1,
                             input int vr2, input int voff, input int ncyc);
        logic prev_ready;
        prev_ready = 1'b0;
        sd_cyc.delete();
        sof_cyc = -1; eof_cyc = -1; done_cyc = -1; acc_cnt = 0; drop_acc = -1;
        blocks_per_frame = nblk;
        for (int c = 0; c < ncyc; c++) begin
            if (c > 0) begin
                if (bus.stats_start_data) sd_cyc.push_back(c);
                if (bus.stats_start_of_frame && sof_cyc < 0) sof_cyc = c;
                if (bus.stats_end_of_frame && eof_cyc < 0) eof_cyc = c;
                if (frame_done && done_cyc < 0) done_cyc = c;
            end
            dat_log[c]   = bus.stats_data;
            err_log[c]   = err;
            code_log[c]  = err_code;
            busy_log[c]  = busy;
            ready_log[c] = bus.s_ready;
            frame_start        = (c == 0);
            bus.s_valid        = (voff < 0) || (c < voff);
            bus.variance_ready = (c == vr0) || (c == vr1) || (c == vr2);
            bus.s_data         = 8'h40 + 8'(c);
            if (prev_ready && !bus.s_ready && drop_acc < 0) drop_acc = acc_cnt;
            if (bus.s_ready && bus.s_valid) acc_cnt++;
            prev_ready = bus.s_ready;
            tick();
        end
        frame_start        = 1'b0;
        bus.variance_ready = 1'b0;
        bus.s_valid        = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        frame_start = 1'b0;
        blocks_per_frame = 32'd0;
        bus.s_valid = 1'b0;
        bus.s_data = 8'h00;
        bus.variance_ready = 1'b0;
        repeat (3) tick();

        chk("rst_busy", busy, 0);
        chk("rst_s_ready", bus.s_ready, 0);
        chk("rst_stats_data", bus.stats_data, 0);
        chk("rst_start_data", bus.stats_start_data, 0);
        chk("rst_sof", bus.stats_start_of_frame, 0);
        chk("rst_eof", bus.stats_end_of_frame, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_err", err, 0);
        chk("rst_err_code", err_code, 0);
        rst_n = 1'b1;
        tick();

        // Normal frame: 3 blocks, variance_ready 20 cycles after each block start.
        run_frame(32'd3, 23, 31, 44, -1, 52);
        chk("norm_sof", sof_cyc, 1);
        chk("norm_sd_count", sd_cyc.size(), 3);
        chk("norm_sd0", sd_at(0), 4);
        chk("norm_sd1", sd_at(1), 12);
        chk("norm_sd2", sd_at(2), 25);
        chk("norm_eof", eof_cyc, 32);
        chk("norm_done", done_cyc, 46);
        chk("norm_accepted", acc_cnt, 24);
        chk("norm_drop_after", drop_acc, 16);
        chk("norm_data_first", dat_log[4], 8'h43);
        chk("norm_data_last", dat_log[32], 8'h5F);
        chk("norm_idle_busy", busy, 0);
        chk("norm_err", err, 0);

        // Credit stall: first credit returns late; third block starts right after it.
        run_frame(32'd3, 39, 49, 51, -1, 60);
        chk("stall_drop_after", drop_acc, 16);
        chk("stall_ready_low", ready_log[39], 0);
        chk("stall_sd2", sd_at(2), 41);
        chk("stall_eof", eof_cyc, 48);
        chk("stall_done", done_cyc, 53);

        // Credit returned on the same edge as block 1 starts: block 2 follows back-to-back.
        run_frame(32'd3, 11, 27, 36, -1, 45);
        chk("simul_sd2", sd_at(2), 20);
        chk("simul_drop_after", drop_acc, 24);
        chk("simul_eof", eof_cyc, 27);
        chk("simul_done", done_cyc, 38);

        // Underrun at sample 5 of block 0.
        run_frame(32'd2, -1, -1, -1, 8, 30);
        chk("under_accepted", acc_cnt, 5);
        chk("under_err", err_log[9], 1);
        chk("under_code", code_log[9], 2);
        chk("under_ready", ready_log[9], 0);
        chk("under_busy", busy_log[9], 1);
        chk("under_no_done", done_cyc, -1);

        // Config error (issued from the error state): blocks_per_frame=0.
        run_frame(32'd0, -1, -1, -1, -1, 4);
        chk("cfg_err", err_log[1], 1);
        chk("cfg_code", code_log[1], 1);
        chk("cfg_busy", busy_log[1], 1);
        chk("cfg_no_sof", sof_cyc, -1);

        // Spurious variance_ready in IDLE.
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        chk("spur_pre_err", err, 0);
        bus.variance_ready = 1'b1;
        tick();
        bus.variance_ready = 1'b0;
        chk("spur_err", err, 1);
        chk("spur_code", err_code, 3);
        chk("spur_busy", busy, 1);

        // Reset mid-stream at sample 3 of block 1, then a clean frame.
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        run_frame(32'd3, -1, -1, -1, -1, 15);
        chk("mid_pre_busy", busy, 1);
        chk("mid_pre_data", bus.stats_data, 8'h4E);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", bus.s_ready, 0);
        chk("mid_rst_data", bus.stats_data, 0);
        chk("mid_rst_err", err, 0);
        #2;
        rst_n = 1'b1;
        tick();
        run_frame(32'd3, 23, 31, 44, -1, 52);
        chk("clean_sd_count", sd_cyc.size(), 3);
        chk("clean_sd2", sd_at(2), 25);
        chk("clean_eof", eof_cyc, 32);
        chk("clean_done", done_cyc, 46);
        chk("clean_err", err, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
